// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Holds the FSM state type, the grant-index width helper and the beat counter width.
package fifo_arb_pkg;

  localparam int BEAT_W = 8;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_BURST = 1'b1;

  // Grant index width; kept at least 1 bit so the smallest configuration still has a port.
  function automatic int gw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: the first requester above last_gnt (with wrap) wins.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = gw_of(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_last_gnt,
  output logic [GW-1:0]      o_winner,
  output logic               o_any_req
);

  int w_dist;
  int w_best;

  // Distance 0 is the requester just after the last winner; the last winner itself is farthest.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + 2 * NUM_REQ - 1 - int'(i_last_gnt)) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        o_winner  = GW'(j);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port among NUM_REQ producers.
// A grant lasts until the owner's last beat or MAX_BURST beats; writes stall while the FIFO is full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  NUM_REQ   = 4,
  parameter int  MAX_BURST = 4,
  localparam int GW        = gw_of(NUM_REQ)
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wr_data,
  output logic                     grant_valid,
  output logic [GW-1:0]            grant_id,
  output logic [BEAT_W-1:0]        beat_cnt
);

  state_t            r_state;
  logic [GW-1:0]     r_last_gnt;
  logic [GW-1:0]     r_grant_id;
  logic [BEAT_W-1:0] r_beat_cnt;

  logic [WIDTH-1:0]  w_data [NUM_REQ];
  logic [GW-1:0]     w_winner;
  logic              w_any_req;
  logic              w_ready;
  logic              w_accept;
  logic              w_release;
  logic [BEAT_W-1:0] w_cnt_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .i_req      (req_valid),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_any_req  (w_any_req)
  );

  // Ready is gated by rst so nothing is offered or written during a reset cycle.
  assign w_ready = (r_state == ST_BURST) && !fifo_full && !rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_data[gi]    = req_data[gi*WIDTH +: WIDTH];
    assign req_ready[gi] = w_ready && (r_grant_id == GW'(gi));
  end

  assign w_accept  = w_ready && req_valid[r_grant_id];
  assign w_cnt_inc = r_beat_cnt + 1'b1;
  assign w_release = w_accept && (req_last[r_grant_id] || (w_cnt_inc == BEAT_W'(MAX_BURST)));

  assign fifo_wr_en   = w_accept;
  assign fifo_wr_data = w_accept ? w_data[r_grant_id] : '0;

  assign grant_valid = (r_state == ST_BURST);
  assign grant_id    = r_grant_id;
  assign beat_cnt    = r_beat_cnt;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= GW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant_id <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Owner holds the port through valid gaps and full stalls until it releases.
          if (w_release) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= r_grant_id;
            r_beat_cnt <= '0;
          end else if (w_accept) begin
            r_beat_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter with a 16-deep FIFO occupancy model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int GW    = 2;
  localparam int DEPTH = 16;

  logic             wr_clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [N*W-1:0]   req_data;
  logic             fifo_full, fifo_wr_en;
  logic [W-1:0]     fifo_wr_data;
  logic             grant_valid;
  logic [GW-1:0]    grant_id;
  logic [7:0]       beat_cnt;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .beat_cnt     (beat_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {int id; int data;} exp_t;
  exp_t sb[$];
  int   log_data[$], log_id[$], log_cyc[$];

  int checks = 0, errors = 0, cyc = 0;
  int seq[N], rem[N], pkts[N], base[N];
  int fixed_len = 0, vld_pct = 100, rd_pct = 100, fifo_cnt = 0;
  // Reference arbiter: owner -1 means nobody holds the port.
  int m_owner = -1, m_last = N - 1, m_gid = 0, m_cnt = 0;
  bit seen_rst = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int beat_val(input int i);
    return base[i] + (seq[i] % 64);
  endfunction

  task automatic step(input bit r);
    bit rd;
    int exp_ready;
    bit acc;
    bit found;
    int o;
    @(negedge wr_clk);
    cyc++;
    rst = r;
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && pkts[i] != 0) begin
        rem[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 6));
        if (pkts[i] > 0) pkts[i]--;
      end
      req_valid[i] = (rem[i] > 0) && ($urandom_range(0, 99) < vld_pct);
      req_last[i]  = (rem[i] == 1);
      req_data[i*W +: W] = W'(beat_val(i));
    end
    fifo_full = (fifo_cnt >= DEPTH);
    rd = (fifo_cnt > 0) && ($urandom_range(0, 99) < rd_pct);
    #1;
    exp_ready = 0;
    acc = 0;
    if (seen_rst) begin
      chk("grant_valid", int'(grant_valid), (m_owner >= 0) ? 1 : 0);
      chk("grant_id", int'(grant_id), m_gid);
      chk("beat_cnt", int'(beat_cnt), m_cnt);
    end
    if (r) begin
      m_owner = -1; m_last = N - 1; m_gid = 0; m_cnt = 0; seen_rst = 1;
    end else if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (!found && req_valid[j[GW-1:0]]) begin
          found = 1; m_owner = j; m_gid = j; m_cnt = 0;
        end
      end
    end else begin
      o = m_owner;
      if (!fifo_full) exp_ready = 1 << o;
      if (!fifo_full && req_valid[o[GW-1:0]]) begin
        acc = 1;
        sb.push_back('{o, beat_val(o)});
        m_cnt++;
        if (req_last[o[GW-1:0]] || m_cnt == MB) begin
          m_last = o; m_owner = -1; m_cnt = 0;
        end
        seq[o]++;
        rem[o]--;
      end
    end
    chk("req_ready", int'(req_ready), exp_ready);
    chk("fifo_wr_en", int'(fifo_wr_en), int'(acc));
    if (fifo_wr_en === 1'b1 && fifo_cnt < DEPTH) fifo_cnt++;
    if (rd) fifo_cnt--;
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes the FIFO.
  always @(negedge wr_clk) begin
    #2;
    if (fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_data", int'(fifo_wr_data), e.data);
        chk("wr_owner", int'(grant_id), e.id);
      end
      log_data.push_back(int'(fifo_wr_data));
      log_id.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
    end
  end

  task automatic setup(input int len, input int np, input int vp, input int rp);
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; rem[i] = 0; pkts[i] = np;
    end
    fixed_len = len; vld_pct = vp; rd_pct = rp;
  endtask

  function automatic int qget(input int k);
    return (log_data.size() > k) ? log_data[k] : -1;
  endfunction

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    setup(0, 0, 100, 100);
    for (int i = 0; i < N; i++) base[i] = 0;

    // Reset state with no requests pending.
    step(1); step(1);
    for (int c = 0; c < 4; c++) step(0);

    // All four requesters, one 2-beat packet each, requester 0 first.
    step(1);
    setup(2, 1, 100, 100);
    for (int i = 0; i < N; i++) base[i] = 16 * (i + 1);
    log_data.delete(); log_id.delete(); log_cyc.delete();
    for (int c = 0; c < 20; c++) step(0);
    chk("t1_count", log_data.size(), 8);
    for (int k = 0; k < 8; k++) chk("t1_order", qget(k), 16 * (k / 2 + 1) + k % 2);
    if (log_id.size() >= 8) begin
      for (int k = 0; k < 4; k++) chk("t1_grant_seq", log_id[2*k], k);
      chk("t1_idle_gap", log_cyc[2] - log_cyc[1], 2);
    end

    // Lone requester 3 with 1-beat packets: one write every 2 clocks.
    step(1);
    setup(1, 0, 100, 100);
    pkts[3] = 6; base[3] = 8'h70;
    log_data.delete(); log_id.delete(); log_cyc.delete();
    for (int c = 0; c < 20; c++) step(0);
    chk("t6_count", log_data.size(), 6);
    if (log_cyc.size() >= 6) begin
      for (int k = 0; k < 5; k++) begin
        chk("t6_spacing", log_cyc[k+1] - log_cyc[k], 2);
        chk("t6_grant", log_id[k], 3);
      end
    end

    // Random traffic: bursts past MAX_BURST, valid gaps, FIFO-full stalls, stray resets.
    step(1);
    setup(0, -1, 70, 30);
    for (int i = 0; i < N; i++) base[i] = i << 6;
    for (int c = 0; c < 3000; c++) step($urandom_range(0, 299) == 0);

    // Drain: stop new packets and let open ones complete.
    for (int i = 0; i < N; i++) pkts[i] = 0;
    vld_pct = 100; rd_pct = 100;
    for (int c = 0; c < 100; c++) step(0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
